tc_block_scheduler: RTL and testbench
=====================================

Name: tc_block_scheduler

Overview:
Sequences one 16-block luma macroblock through the 4x4 transform-coding pipeline (transform, quantise, inverse quantise, inverse transform). On `start` it latches QP and derives QP/6 and QP%6 with a sequential divider. It then fetches residual blocks in H.264 4x4 scan order and drives the pipeline `enable`. It tracks each block through the pipeline latency and tags every writeback with its block index. Back-pressure comes from a single `stall` input.

Parameters:
- PIPE_LAT, 4: enabled clock edges from block issue to valid `processedres`; must be ≥1.
- NUM_BLK, 16: 4x4 blocks per macroblock; fixed at 16 for this scan table.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high.
- start  in  1  request to process one macroblock; sampled only in IDLE.
- qp  in  6  quantisation parameter; sampled with `start`.
- stall  in  1  downstream cannot accept; freezes the pipeline.
- busy  out  1  controller is processing.
- qp_err  out  1  one-cycle pulse when `start` carries qp>51.
- qp_by_6  out  4  floor(qp/6), feeds the quant/invquant `QP_BY_6` input.
- qp_mod_6  out  3  qp mod 6, feeds the quant/invquant `QP_MOD_6` input.
- rd_en  out  1  fetch residual block `rd_blk` this cycle.
- rd_blk  out  4  raster index of the block being fetched.
- pipe_enable  out  1  drives `enable` of all four pipeline stages.
- wr_valid  out  1  `processedres` holds the block `wr_blk`.
- wr_blk  out  4  raster index of the block at the pipeline output.
- done  out  1  one-cycle pulse once the last block is written back.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0 immediately; the FSM goes to IDLE.
  - Counters, the tag pipe and the QP registers clear.
  - Reset asserted mid-operation abandons the macroblock; no `done` is produced.
- Scan table: k-th issued block maps to raster index 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15.
- FSM states: IDLE, QPCALC, ISSUE, DRAIN, DONE. `busy`=1 in every state except IDLE.
- IDLE:
  - `start`=1 and qp≤51: latch rem=qp, quo=0, go to QPCALC.
  - `start`=1 and qp>51: pulse `qp_err` next cycle, stay in IDLE.
  - `start` in any other state is ignored.
- QPCALC:
  - Each cycle with rem≥6: rem-=6, quo+=1.
  - When rem<6: register qp_mod_6=rem and qp_by_6=quo, go to ISSUE.
  - Duration is floor(qp/6)+1 cycles. `stall` is ignored here.
  - qp_by_6/qp_mod_6 stay stable until the next accepted `start`.
- pipe_enable: equals !stall in ISSUE and DRAIN; 0 elsewhere.
- ISSUE:
  - Each cycle with `stall`=0: rd_en=1, rd_blk=scan[issue_cnt], issue_cnt++.
  - After the 16th issue, go to DRAIN.
  - With `stall`=1: rd_en=0 and rd_blk holds.
- Tag pipe: PIPE_LAT stages, each holding a valid bit and a 4-bit index.
  - Shifts only on edges where pipe_enable=1.
  - Stage 0 loads {rd_en, rd_blk}.
  - wr_valid/wr_blk are the last stage, so the first wr_valid appears PIPE_LAT cycles after the first rd_en when unstalled.
- Writeback handshake:
  - A writeback is consumed on a cycle with wr_valid=1 and stall=0.
  - While stalled, wr_valid and wr_blk hold.
  - wb_cnt counts consumed writebacks.
- DRAIN:
  - Pipeline keeps advancing with bubbles (rd_en=0).
  - When the 16th writeback is consumed, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE; busy drops on the following cycle.
- Counters: issue_cnt and wb_cnt are 5 bits, no wrap.
  - Exactly 16 issues and 16 writebacks per macroblock.
  - Each index 0–15 appears exactly once on rd_blk and once on wr_blk, in scan order.
- Unstalled macroblock timing:
  - First rd_en at cycle T.
  - Last rd_en at T+15.
  - Last wr_valid at T+15+PIPE_LAT.
  - `done` on the next cycle.

Test Plan:
1. start with qp=28, stall=0 → QPCALC lasts 5 cycles; qp_by_6=4, qp_mod_6=4; rd_blk sequence 0,1,4,5,2,3,6,7,8,9,12,13,10,11,14,15; wr_blk matches the same sequence, delayed 4 cycles; `done` pulses 20 cycles after the first rd_en.
2. qp=0 → 1-cycle QPCALC, 0/0. qp=51 → 9 cycles, 8/3. qp=35 → 5/5. Values hold through the next idle period.
3. qp=52 and qp=63 → `qp_err` one-cycle pulse; busy, rd_en and pipe_enable stay 0; FSM stays in IDLE.
4. stall high for 3 cycles after the 5th issue, then for 2 cycles while wr_valid=1 in DRAIN → rd_en and pipe_enable low during each stall; wr_valid/wr_blk held; `done` arrives 5 cycles later than case 1; no index is lost or duplicated.
5. start pulsed while busy → ignored; qp_by_6/qp_mod_6 unchanged.
6. reset asserted mid-DRAIN → all outputs 0 asynchronously and no `done`; a fresh start with qp=28 then completes a full 16-block run.

Source files
------------

// File: rtl/tc_block_scheduler.sv
// tc_block_scheduler: sequences one 16-block luma macroblock through the
// 4x4 transform/quant pipeline and tags every writeback with its block.
module tc_block_scheduler #(
  parameter int PIPE_LAT = 4,
  parameter int NUM_BLK  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] qp,
  input  logic       stall,
  output logic       busy,
  output logic       qp_err,
  output logic [3:0] qp_by_6,
  output logic [2:0] qp_mod_6,
  output logic       rd_en,
  output logic [3:0] rd_blk,
  output logic       pipe_enable,
  output logic       wr_valid,
  output logic [3:0] wr_blk,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_QPCALC,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [3:0] SCAN [16] = '{
    4'd0,  4'd1,  4'd4,  4'd5,
    4'd2,  4'd3,  4'd6,  4'd7,
    4'd8,  4'd9,  4'd12, 4'd13,
    4'd10, 4'd11, 4'd14, 4'd15
  };

  state_t r_state;
  state_t w_next;

  logic [5:0] r_rem;
  logic [3:0] r_quo;
  logic [3:0] r_qp_by_6;
  logic [2:0] r_qp_mod_6;
  logic       r_qp_err;
  logic [4:0] r_issue_cnt;
  logic [4:0] r_wb_cnt;

  logic [PIPE_LAT-1:0] r_tag_v;
  logic [3:0]          r_tag_blk [PIPE_LAT];

  logic       w_accept;
  logic       w_reject;
  logic       w_active;
  logic       w_pipe_en;
  logic       w_rd_en;
  logic [3:0] w_rd_blk;
  logic       w_wb_take;
  logic       w_last_issue;
  logic       w_last_wb;

  assign w_accept  = (r_state == S_IDLE) && start && (qp <= 6'd51);
  assign w_reject  = (r_state == S_IDLE) && start && (qp > 6'd51);
  assign w_active  = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign w_pipe_en = w_active && !stall;
  assign w_rd_en   = (r_state == S_ISSUE) && !stall;
  assign w_rd_blk  = SCAN[r_issue_cnt[3:0]];
  assign w_wb_take = r_tag_v[PIPE_LAT-1] && w_pipe_en;

  assign w_last_issue = w_rd_en &&
    (r_issue_cnt == 5'(NUM_BLK - 1));
  assign w_last_wb = w_wb_take &&
    (r_wb_cnt == 5'(NUM_BLK - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_accept) w_next = S_QPCALC;
      S_QPCALC: if (r_rem < 6'd6) w_next = S_ISSUE;
      S_ISSUE:  if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN:  if (w_last_wb) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Divide-by-6 by repeated subtraction; result published on exit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rem      <= '0;
      r_quo      <= '0;
      r_qp_by_6  <= '0;
      r_qp_mod_6 <= '0;
      r_qp_err   <= 1'b0;
    end else begin
      r_qp_err <= w_reject;
      if (w_accept) begin
        r_rem <= qp;
        r_quo <= '0;
      end else if (r_state == S_QPCALC) begin
        if (r_rem >= 6'd6) begin
          r_rem <= r_rem - 6'd6;
          r_quo <= r_quo + 4'd1;
        end else begin
          r_qp_by_6  <= r_quo;
          r_qp_mod_6 <= r_rem[2:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issue_cnt <= '0;
      r_wb_cnt    <= '0;
    end else if (w_accept) begin
      r_issue_cnt <= '0;
      r_wb_cnt    <= '0;
    end else begin
      if (w_rd_en)   r_issue_cnt <= r_issue_cnt + 5'd1;
      if (w_wb_take) r_wb_cnt    <= r_wb_cnt + 5'd1;
    end
  end

  // Tag pipe mirrors the datapath latency; frozen with the pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tag_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_tag_blk[i] <= '0;
      end
    end else if (w_pipe_en) begin
      r_tag_v[0]   <= w_rd_en;
      r_tag_blk[0] <= w_rd_blk;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tag_v[i]   <= r_tag_v[i-1];
        r_tag_blk[i] <= r_tag_blk[i-1];
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign qp_err      = r_qp_err;
  assign qp_by_6     = r_qp_by_6;
  assign qp_mod_6    = r_qp_mod_6;
  assign rd_en       = w_rd_en;
  assign rd_blk      = w_rd_blk;
  assign pipe_enable = w_pipe_en;
  assign wr_valid    = r_tag_v[PIPE_LAT-1];
  assign wr_blk      = r_tag_blk[PIPE_LAT-1];

endmodule

// File: tb/tb_tc_block_scheduler.sv
// tb_tc_block_scheduler: randomized stall/qp runs checked against a
// schedule model built from the list of enabled cycles.
`timescale 1ns/1ps
module tb_tc_block_scheduler;

  localparam int PL     = 4;
  localparam int NB     = 16;
  localparam int NE     = NB + PL;
  localparam int MAXC   = 256;
  localparam int M_CLN  = 0;
  localparam int M_RND  = 1;
  localparam int M_DIR  = 2;
  localparam int M_IGN  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start;
  logic       stall;
  logic [5:0] qp;
  logic       busy;
  logic       qp_err;
  logic [3:0] qp_by_6;
  logic [2:0] qp_mod_6;
  logic       rd_en;
  logic [3:0] rd_blk;
  logic       pipe_enable;
  logic       wr_valid;
  logic [3:0] wr_blk;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;
  int old_q = 0;
  int old_r = 0;

  always #5 clk = ~clk;

  tc_block_scheduler #(
    .PIPE_LAT(PL),
    .NUM_BLK (NB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .qp         (qp),
    .stall      (stall),
    .busy       (busy),
    .qp_err     (qp_err),
    .qp_by_6    (qp_by_6),
    .qp_mod_6   (qp_mod_6),
    .rd_en      (rd_en),
    .rd_blk     (rd_blk),
    .pipe_enable(pipe_enable),
    .wr_valid   (wr_valid),
    .wr_blk     (wr_blk),
    .done       (done)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  // raster index of k-th block in 4x4 scan: bits b3 b1 b2 b0
  function automatic int scan(input int k);
    return ((k >> 3) & 1) * 8 + ((k >> 1) & 1) * 4 +
           ((k >> 2) & 1) * 2 + (k & 1);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_qperr"}, qp_err, 0);
    chk({tag, "_qpby6"}, qp_by_6, 0);
    chk({tag, "_qpmod6"}, qp_mod_6, 0);
    chk({tag, "_rden"}, rd_en, 0);
    chk({tag, "_rdblk"}, rd_blk, 0);
    chk({tag, "_pe"}, pipe_enable, 0);
    chk({tag, "_wrv"}, wr_valid, 0);
    chk({tag, "_wrblk"}, wr_blk, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      stall = 1'($urandom_range(0, 1));
      qp    = 6'($urandom_range(0, 63));
      @(negedge clk);
      chk("idle_busy", busy, 0);
      chk("idle_rden", rd_en, 0);
      chk("idle_pe", pipe_enable, 0);
      chk("idle_done", done, 0);
      chk("idle_qpby6", qp_by_6, old_q);
      chk("idle_qpmod6", qp_mod_6, old_r);
    end
  endtask

  task automatic bad_qp(input int q);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      start = (c == 0);
      qp    = 6'(q);
      stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("bad_qperr", qp_err, (c == 1) ? 1 : 0);
      chk("bad_busy", busy, 0);
      chk("bad_rden", rd_en, 0);
      chk("bad_pe", pipe_enable, 0);
      chk("bad_qpby6", qp_by_6, old_q);
      chk("bad_qpmod6", qp_mod_6, old_r);
    end
  endtask

  task automatic run_mb(input int q, input int mode, input bit abort);
    int st [MAXC];
    int en [NE];
    int ne;
    int icyc, d, ign, ab, fr, fd;
    int e_rd, e_rb, e_wv, e_wb, e_pe;
    ne   = 0;
    icyc = 2 + q / 6;
    for (int c = 0; c < MAXC; c++)
      st[c] = (mode == M_RND) ? int'($urandom_range(0, 2) == 0) : 0;
    if (mode == M_DIR) begin
      st[icyc + 5]       = 1;
      st[icyc + 6]       = 1;
      st[icyc + 7]       = 1;
      st[icyc + 18 + PL] = 1;
      st[icyc + 19 + PL] = 1;
    end
    for (int c = icyc; c < MAXC && ne < NE; c++)
      if (st[c] == 0) begin
        en[ne] = c;
        ne++;
      end
    if (ne < NE) begin
      chk("stall_budget", ne, NE);
      return;
    end
    d   = en[NE-1] + 1;
    ign = (mode == M_RND || mode == M_IGN) ?
          int'($urandom_range(1, d)) : -1;
    ab  = abort ? en[NB+1] : -1;
    fr  = -1;
    fd  = -1;
    for (int c = 0; c <= d + 2; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (c == ign);
      qp    = (c == 0) ? 6'(q) : 6'($urandom_range(0, 63));
      stall = (st[c] != 0);
      if (c == ab) begin
        #2 reset = 1'b1;
        #1 check_zero("abort");
        old_q = 0;
        old_r = 0;
        @(posedge clk); #1;
        start = 1'b0;
        stall = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          chk("abort_done", done, 0);
          chk("abort_busy", busy, 0);
          @(posedge clk); #1;
        end
        return;
      end
      @(negedge clk);
      e_rd = 0; e_rb = 0; e_wv = 0; e_wb = 0;
      for (int k = 0; k < NB; k++) begin
        if (en[k] == c) begin
          e_rd = 1;
          e_rb = scan(k);
        end
        if (c > en[k+PL-1] && c <= en[k+PL]) begin
          e_wv = 1;
          e_wb = scan(k);
        end
      end
      e_pe = (c >= icyc && c <= en[NE-1] && st[c] == 0) ? 1 : 0;
      chk("busy", busy, (c >= 1 && c <= d) ? 1 : 0);
      chk("done", done, (c == d) ? 1 : 0);
      chk("qp_err", qp_err, 0);
      chk("rd_en", rd_en, e_rd);
      chk("pipe_en", pipe_enable, e_pe);
      chk("wr_valid", wr_valid, e_wv);
      if (e_rd != 0) chk("rd_blk", rd_blk, e_rb);
      if (e_wv != 0) chk("wr_blk", wr_blk, e_wb);
      chk("qp_by_6", qp_by_6, (c >= icyc) ? q / 6 : old_q);
      chk("qp_mod_6", qp_mod_6, (c >= icyc) ? q % 6 : old_r);
      if (rd_en && fr < 0) fr = c;
      if (done && fd < 0) fd = c;
    end
    old_q = q / 6;
    old_r = q % 6;
    if (mode == M_CLN || mode == M_DIR) begin
      chk("first_rd_cycle", fr, icyc);
      chk("done_cycle", fd,
          icyc + NB + PL + ((mode == M_DIR) ? 5 : 0));
    end
  endtask

  initial begin
    start = 1'b0;
    stall = 1'b0;
    qp    = '0;
    #1 reset = 1'b1;
    #1 check_zero("por");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    run_mb(28, M_CLN, 1'b0);
    idle(3);
    run_mb(0, M_CLN, 1'b0);
    idle(3);
    run_mb(51, M_CLN, 1'b0);
    idle(3);
    run_mb(35, M_CLN, 1'b0);
    idle(4);
    bad_qp(52);
    bad_qp(63);
    idle(2);
    run_mb(28, M_DIR, 1'b0);
    run_mb(40, M_IGN, 1'b0);
    idle(2);
    run_mb(28, M_CLN, 1'b1);
    run_mb(28, M_CLN, 1'b0);

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(0, 4) == 0)
        bad_qp(int'($urandom_range(52, 63)));
      run_mb(int'($urandom_range(0, 51)), M_RND, 1'b0);
      idle(int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
